// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU fetch/memory stages, the arbiter and the unified memory.
// The master modport is the arbiter's view; slave is the surrounding pipeline/memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        err;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_ready, if_rdata, d_ready, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, err
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_mem, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access, with a
// grant watchdog. Define ARB_RR_EN for round-robin tie-break instead of data priority.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   wdog_q, wdog_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   wdog_inc;
  logic              timeout;
  logic              pick_data;
  logic              gnt_i, gnt_d;

`ifdef ARB_RR_EN
  logic              last_data_q, last_data_d;

  // On a tie the requester that was not served last wins; a lone request always wins.
  assign pick_data = bus.d_req && (!bus.if_req || !last_data_q);
`else
  assign pick_data = bus.d_req;
`endif

  assign wdog_inc = wdog_q + 1'b1;
  assign timeout  = (wdog_inc == TIMEOUT_C);
  assign gnt_i    = (state_q == GNT_I);
  assign gnt_d    = (state_q == GNT_D);

  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = err_q;
`ifdef ARB_RR_EN
    last_data_d = last_data_q;
`endif
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (pick_data) begin
          state_d = GNT_D;
        end else if (bus.if_req) begin
          state_d = GNT_I;
        end
      end
      GNT_I: begin
        wdog_d = wdog_inc;
        if (bus.mem_ack || timeout) begin
          state_d    = DONE;
          if_ready_d = 1'b1;
          if_rdata_d = bus.mem_ack ? bus.mem_rdata : 32'h0;
          err_d      = err_q | ~bus.mem_ack;
`ifdef ARB_RR_EN
          last_data_d = 1'b0;
`endif
        end
      end
      GNT_D: begin
        wdog_d = wdog_inc;
        if (bus.mem_ack || timeout) begin
          state_d   = DONE;
          d_ready_d = 1'b1;
          // A store leaves the load-data register untouched, even on abort.
          if (!bus.d_we) begin
            d_rdata_d = bus.mem_ack ? bus.mem_rdata : 32'h0;
          end
          err_d     = err_q | ~bus.mem_ack;
`ifdef ARB_RR_EN
          last_data_d = 1'b1;
`endif
        end
      end
      DONE: begin
        wdog_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        wdog_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wdog_q     <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
      err_q      <= 1'b0;
`ifdef ARB_RR_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
`ifdef ARB_RR_EN
      last_data_q <= last_data_d;
`endif
    end
  end

  // Memory side is decoded straight from the state so an async reset drops mem_req at once.
  assign bus.mem_req   = gnt_i | gnt_d;
  assign bus.mem_we    = gnt_d & bus.d_we;
  assign bus.mem_addr  = gnt_i ? bus.if_addr : (gnt_d ? bus.d_addr : 32'h0);
  assign bus.mem_wdata = gnt_d ? bus.d_wdata : 32'h0;

  assign bus.if_ready  = if_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_mem = bus.d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 16;
  localparam int NONE  = 0;
  localparam int FETCH = 1;
  localparam int DATA  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the memory, how many grant cycles have elapsed, who gets a ready pulse.
  int          m_owner, m_done, m_age;
  logic [31:0] m_if_rdata, m_d_rdata;
  logic        m_err, m_last_data;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner <= NONE; m_done <= NONE; m_age <= 0;
      m_if_rdata <= 32'h0; m_d_rdata <= 32'h0; m_err <= 1'b0; m_last_data <= 1'b0;
    end else if (m_done != NONE) begin
      m_done <= NONE;
    end else if (m_owner != NONE) begin
      m_age <= m_age + 1;
      if (bus.mem_ack || (m_age + 1 == TIMEOUT)) begin
        m_done      <= m_owner;
        m_owner     <= NONE;
        m_last_data <= (m_owner == DATA);
        if (!bus.mem_ack) m_err <= 1'b1;
        if (m_owner == FETCH) m_if_rdata <= bus.mem_ack ? bus.mem_rdata : 32'h0;
        else if (!bus.d_we)   m_d_rdata  <= bus.mem_ack ? bus.mem_rdata : 32'h0;
      end
    end else begin
      m_age <= 0;
      if (bus.d_req && bus.if_req) begin
`ifdef ARB_RR_EN
        m_owner <= m_last_data ? FETCH : DATA;
`else
        m_owner <= DATA;
`endif
      end else if (bus.d_req) m_owner <= DATA;
      else if (bus.if_req)    m_owner <= FETCH;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("mem_req",   bus.mem_req,   32'(m_owner != NONE));
      check("mem_we",    bus.mem_we,    32'(m_owner == DATA && bus.d_we));
      check("mem_addr",  bus.mem_addr,  m_owner == FETCH ? bus.if_addr :
                                        (m_owner == DATA ? bus.d_addr : 32'h0));
      check("mem_wdata", bus.mem_wdata, m_owner == DATA ? bus.d_wdata : 32'h0);
      check("if_ready",  bus.if_ready,  32'(m_done == FETCH));
      check("d_ready",   bus.d_ready,   32'(m_done == DATA));
      check("if_rdata",  bus.if_rdata,  m_if_rdata);
      check("d_rdata",   bus.d_rdata,   m_d_rdata);
      check("err",       bus.err,       32'(m_err));
      check("stall_if",  bus.stall_if,  32'(bus.if_req && m_done != FETCH));
      check("stall_mem", bus.stall_mem, 32'(bus.d_req && m_done != DATA));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  logic        data_first;
  logic        saw_if, saw_d, prev_req, dead;
  logic [31:0] first_addr, second_addr, first_rd, second_rd;

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
    repeat (3) tick;
    reset = 1'b1;
    tick;
    smp;
    check("rst_mem_req", bus.mem_req, 32'h0);
    check("rst_ready",   {bus.if_ready, bus.d_ready, bus.err}, 32'h0);
    check("rst_rdata",   bus.if_rdata | bus.d_rdata, 32'h0);

    // Fetch with ack in the first grant cycle.
    tick; bus.if_req = 1; bus.if_addr = 32'h10;
    smp;  check("f_stall_c0", bus.stall_if, 32'h1);
    tick; bus.mem_ack = 1; bus.mem_rdata = 32'h2008_0005;
    smp;  check("f_req_c1", bus.mem_req, 32'h1);
          check("f_addr_c1", bus.mem_addr, 32'h10);
          check("f_we_c1", bus.mem_we, 32'h0);
          check("f_stall_c1", bus.stall_if, 32'h1);
    tick; bus.mem_ack = 0;
    smp;  check("f_ready_c2", bus.if_ready, 32'h1);
          check("f_rdata_c2", bus.if_rdata, 32'h2008_0005);
    tick; bus.if_req = 0;

    // Store acked after three wait cycles.
    tick; bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h54; bus.d_wdata = 32'hCAFE_F00D;
    for (int k = 1; k <= 4; k++) begin
      tick; bus.mem_ack = (k == 4);
      smp;  check("st_we", bus.mem_we, 32'h1);
            check("st_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    end
    tick; bus.mem_ack = 0;
    smp;  check("st_ready", bus.d_ready, 32'h1);
          check("st_rdata", bus.d_rdata, 32'h0);
    tick; bus.d_req = 0; bus.d_we = 0;
    smp;  check("st_ready_once", bus.d_ready, 32'h0);

    // Simultaneous requests; the last served requester was data (the store).
`ifdef ARB_RR_EN
    data_first = 1'b0;
`else
    data_first = 1'b1;
`endif
    first_addr  = data_first ? 32'h80 : 32'h100;
    second_addr = data_first ? 32'h100 : 32'h80;
    first_rd    = data_first ? 32'h7 : 32'h1111_1111;
    second_rd   = data_first ? 32'h1111_1111 : 32'h7;
    tick; bus.d_req = 1; bus.d_addr = 32'h80; bus.if_req = 1; bus.if_addr = 32'h100;
    tick; bus.mem_ack = 1; bus.mem_rdata = first_rd;
    smp;  check("sim_first_addr", bus.mem_addr, first_addr);
    tick; bus.mem_ack = 0;
    smp;  check("sim_first_ready", data_first ? bus.d_ready : bus.if_ready, 32'h1);
    tick; if (data_first) bus.d_req = 0; else bus.if_req = 0;
    smp;  check("sim_gap", bus.mem_req, 32'h0);
    tick; bus.mem_ack = 1; bus.mem_rdata = second_rd;
    smp;  check("sim_second_addr", bus.mem_addr, second_addr);
    tick; bus.mem_ack = 0;
    smp;  check("sim_d_rdata", bus.d_rdata, 32'h7);
          check("sim_if_rdata", bus.if_rdata, 32'h1111_1111);
    tick; bus.d_req = 0; bus.if_req = 0;

    // Load that never gets an ack.
    tick; bus.d_req = 1; bus.d_addr = 32'h200;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick;
      smp; check("to_req_held", bus.mem_req, 32'h1);
    end
    check("to_err_before", bus.err, 32'h0);
    tick;
    smp;  check("to_ready", bus.d_ready, 32'h1);
          check("to_rdata", bus.d_rdata, 32'h0);
          check("to_err", bus.err, 32'h1);
    tick; bus.d_req = 0;

    // Stray ack while idle.
    tick; bus.mem_ack = 1;
    smp;  check("stray_req", bus.mem_req, 32'h0);
    tick; bus.mem_ack = 0;
    smp;  check("stray_ready", {bus.if_ready, bus.d_ready}, 32'h0);

    // err survives a successful access.
    tick; bus.if_req = 1; bus.if_addr = 32'h20;
    tick; bus.mem_ack = 1; bus.mem_rdata = 32'hABCD;
    tick; bus.mem_ack = 0;
    smp;  check("err_sticky", bus.err, 32'h1);
          check("sticky_rdata", bus.if_rdata, 32'hABCD);
    tick; bus.if_req = 0;

    // Asynchronous reset in the middle of a data grant.
    tick; bus.d_req = 1; bus.d_addr = 32'h300;
    tick;
    smp;  check("ar_req_before", bus.mem_req, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("ar_req_async", bus.mem_req, 32'h0);
    check("ar_outputs", {bus.mem_addr[0], bus.if_ready, bus.d_ready, bus.err}, 32'h0);
    check("ar_rdata", bus.if_rdata | bus.d_rdata | bus.mem_addr, 32'h0);
    tick; reset = 1'b1;
    tick; bus.mem_ack = 1; bus.mem_rdata = 32'h55;
    smp;  check("ar_regrant", bus.mem_addr, 32'h300);
    tick; bus.mem_ack = 0;
    smp;  check("ar_rdata_after", bus.d_rdata, 32'h55);
    tick; bus.d_req = 0;

    // Random traffic; requesters only change their inputs after seeing ready.
    prev_req = 1'b0;
    dead = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      saw_if = bus.if_ready;
      saw_d  = bus.d_ready;
      @(posedge clk);
      #1;
      if (bus.if_req && saw_if) bus.if_req = 0;
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req  = 1;
        bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (bus.d_req && saw_d) bus.d_req = 0;
      if (!bus.d_req && $urandom_range(0, 2) == 0) begin
        bus.d_req   = 1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom & 32'hFFFF_FFFC;
        bus.d_wdata = $urandom;
      end
      if (bus.mem_req) begin
        if (!prev_req) dead = ($urandom_range(0, 7) == 0);
        bus.mem_ack = !dead && ($urandom_range(0, 2) == 0);
      end else begin
        bus.mem_ack = ($urandom_range(0, 9) == 0);
      end
      bus.mem_rdata = $urandom;
      prev_req = bus.mem_req;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
